counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised multi-channel successor to the single 12-bit pattern counter. Holds NUM_CH independent up/down counters, each with its own step multiplier (Xmode), load value, terminal limit and wrap/saturate policy. Each channel emits a one-cycle terminal-count pulse, so the pattern engine can chain periods without external comparators. Sits between the pattern sequencer (configuration and strobes) and the pattern address/timing logic (consumes `out` and `tc`).

## Interface
- WIDTH, 12, counter width per channel (≥4)
- NUM_CH, 4, number of independent channels (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cnt_enb  in  NUM_CH  per-channel count enable
- load  in  NUM_CH  per-channel synchronous load strobe
- Xmode  in  2*NUM_CH  per-channel step select, channel i at [2i+1:2i]
- dir  in  NUM_CH  1 = count up, 0 = count down
- wrap_en  in  NUM_CH  1 = reload on terminal, 0 = saturate
- LoadVal  in  WIDTH*NUM_CH  per-channel load/reload value, channel i at [WIDTH*i +: WIDTH]
- limit  in  WIDTH*NUM_CH  per-channel upper terminal value
- out  out  WIDTH*NUM_CH  per-channel count, registered
- tc  out  NUM_CH  per-channel terminal-count pulse, registered

## Operation
- Step decode per channel: Xmode 00→1, 01→2, 10→4, 11→8.
- Per channel, evaluated every rising edge, in priority order:
  - load=1: out←LoadVal, tc←0, regardless of cnt_enb.
  - cnt_enb=0: out holds, tc←0.
  - Up (dir=1): sum = out + step in WIDTH+1 bits.
    - sum ≤ limit: out←sum, tc←0.
    - sum > limit (terminal event), wrap_en=1: out←LoadVal, tc←1.
    - Terminal event, wrap_en=0: out←limit; tc←1 only if out≠limit before the edge, else 0.
  - Down (dir=0):
    - out ≥ step: out←out−step, tc←0.
    - out < step (terminal event), wrap_en=1: out←LoadVal, tc←1.
    - Terminal event, wrap_en=0: out←0; tc←1 only if out≠0 before the edge.
- Exact hit (sum == limit, or out == step going down) is not a terminal event. The value lands on limit/0 with no tc; the next enabled step triggers the terminal event.
- LoadVal > limit is legal. It is loaded as-is, and the next enabled up step is a terminal event.
- Xmode, dir, wrap_en, limit and LoadVal are sampled every edge and may change any cycle. No shadowing.
- Channels are fully independent. No shared state.

## Timing
- Reset (rst_n=0): out=0 and tc=0 for all channels immediately, asynchronous to clk. They hold while low. Counting resumes on the first rising edge after deassertion.
- Reset mid-count: clears at once. The pending load or step is discarded.
- Latency: one cycle. Inputs sampled at edge N are reflected in out/tc after edge N.
- tc is high for exactly one cycle per terminal event. It is coincident with the updated out (reload or saturated value).
- Back-to-back terminal events in wrap mode give tc on consecutive cycles, for example when LoadVal+step > limit.
- No combinational path from any input to out or tc.

## Structure
- Package `counter_bank_pkg`:
  - xmode enum (X1, X2, X4, X8)
  - step-decode function (xmode → WIDTH-independent 4-bit step)
  - default WIDTH/NUM_CH constants
- Sub-module `counter_channel` (WIDTH parameter) implements one channel. `counter_bank` is a generate loop of NUM_CH instances plus vector slicing.

## Test plan
- Reset: drive rst_n low mid-count on a channel at 37 → out=0 and tc=0 before the next edge; after release with load=0 and cnt_enb=1, dir=1, X1 → out 1, 2, 3.
- Step modes: LoadVal=50, limit=4095, dir=1, wrap_en=1; load then enable with Xmode 00/01/10/11 → out steps 51, 53, 57, 65 on successive edges as the mode changes 1→2→4→8.
- Up wrap: WIDTH=12, limit=4095, LoadVal=4000, X8, wrap_en=1 → terminal event when out=4088 (4088+8>4095): out←4000 with tc=1 for one cycle. At out=4080 the step lands on 4088 with no tc.
- Up saturate: limit=100, out=98, X4, wrap_en=0 → out=100, tc=1; next enabled edge → out=100, tc=0.
- Down wrap/saturate: out=3, X4, dir=0 → with wrap_en=1, out←LoadVal (50), tc=1; with wrap_en=0, out←0, tc=1, then stays 0 with tc=0.
- Multi-channel/priority: load=1 with cnt_enb=1 on ch0 (LoadVal=7) while ch1 counts X2 → ch0 out=7, tc=0; ch1 advances by 2, unaffected. Also check that LoadVal=200 > limit=100 followed by one up step gives tc=1.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the multi-channel pattern counter bank.
package counter_bank_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 12;
  localparam int unsigned DEFAULT_NUM_CH = 4;
  localparam int unsigned STEP_W         = 4;

  typedef enum logic [1:0] {
    X1 = 2'b00,
    X2 = 2'b01,
    X4 = 2'b10,
    X8 = 2'b11
  } xmode_e;

  // Step size is independent of counter width; largest step is 8.
  function automatic logic [STEP_W-1:0] step_of(input xmode_e mode);
    logic [STEP_W-1:0] step;
    unique case (mode)
      X1:      step = STEP_W'(1);
      X2:      step = STEP_W'(2);
      X4:      step = STEP_W'(4);
      default: step = STEP_W'(8);
    endcase
    return step;
  endfunction

endpackage : counter_bank_pkg

// File: rtl/counter_channel.sv
// One up/down counter channel with load, terminal limit, wrap/saturate policy
// and a registered one-cycle terminal-count pulse.
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_enb_i,
  input  logic             load_i,
  input  xmode_e           xmode_i,
  input  logic             dir_i,
  input  logic             wrap_en_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] out_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH:0]   sum_c;

  // Up-count sum carries one extra bit so overflow past limit is visible.
  assign step_c = WIDTH'(step_of(xmode_i));
  assign sum_c  = {1'b0, out_q} + {1'b0, step_c};

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (load_i) begin
      out_d = load_val_i;
    end else if (cnt_enb_i) begin
      if (dir_i) begin
        if (sum_c <= {1'b0, limit_i}) begin
          out_d = sum_c[WIDTH-1:0];
        end else if (wrap_en_i) begin
          out_d = load_val_i;
          tc_d  = 1'b1;
        end else begin
          out_d = limit_i;
          tc_d  = (out_q != limit_i);
        end
      end else begin
        if (out_q >= step_c) begin
          out_d = out_q - step_c;
        end else if (wrap_en_i) begin
          out_d = load_val_i;
          tc_d  = 1'b1;
        end else begin
          out_d = '0;
          tc_d  = (out_q != '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign out_o = out_q;
  assign tc_o  = tc_q;

endmodule : counter_channel

// File: rtl/counter_bank.sv
// NUM_CH independent counter channels; slices the flat vector ports per channel.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned NUM_CH = DEFAULT_NUM_CH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       cnt_enb,
  input  logic [NUM_CH-1:0]       load,
  input  logic [2*NUM_CH-1:0]     Xmode,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       wrap_en,
  input  logic [WIDTH*NUM_CH-1:0] LoadVal,
  input  logic [WIDTH*NUM_CH-1:0] limit,
  output logic [WIDTH*NUM_CH-1:0] out,
  output logic [NUM_CH-1:0]       tc
);

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_enb_i  (cnt_enb[i]),
      .load_i     (load[i]),
      .xmode_i    (xmode_e'(Xmode[2*i +: 2])),
      .dir_i      (dir[i]),
      .wrap_en_i  (wrap_en[i]),
      .load_val_i (LoadVal[WIDTH*i +: WIDTH]),
      .limit_i    (limit[WIDTH*i +: WIDTH]),
      .out_o      (out[WIDTH*i +: WIDTH]),
      .tc_o       (tc[i])
    );
  end

endmodule : counter_bank

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: arithmetic reference model checked every
// cycle, plus hand-computed expectations at key points.
module tb_counter_bank;

  localparam int W  = 12;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   cnt_enb, load, dir, wrap_en, tc;
  logic [2*NC-1:0] Xmode;
  logic [W*NC-1:0] LoadVal, limit, out;

  int checks = 0;
  int errors = 0;
  int m_out [NC];
  int m_tc  [NC];

  counter_bank #(.WIDTH(W), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_enb(cnt_enb), .load(load), .Xmode(Xmode),
    .dir(dir), .wrap_en(wrap_en), .LoadVal(LoadVal), .limit(limit),
    .out(out), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)", name, ch, act, exp, $time);
    end
  endtask

  function automatic int dut_out(input int ch);
    return int'(out[W*ch +: W]);
  endfunction

  // Literal expectation for one channel's count and pulse.
  task automatic expect_ch(input string name, input int ch, input int eo, input int et);
    check({name, ".out"}, ch, dut_out(ch), eo);
    check({name, ".tc"}, ch, int'(tc[ch]), et);
  endtask

  // Reference model: plain integer arithmetic from the counting rules.
  always @(posedge clk or negedge rst_n) begin
    int o, st, lim, lv;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_out[c] = 0;
        m_tc[c]  = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        o   = m_out[c];
        st  = 1 << int'(Xmode[2*c +: 2]);
        lim = int'(limit[W*c +: W]);
        lv  = int'(LoadVal[W*c +: W]);
        m_tc[c] = 0;
        if (load[c]) m_out[c] = lv;
        else if (cnt_enb[c]) begin
          if (dir[c]) begin
            if (o + st <= lim) m_out[c] = o + st;
            else if (wrap_en[c]) begin m_out[c] = lv; m_tc[c] = 1; end
            else begin m_out[c] = lim; m_tc[c] = (o != lim) ? 1 : 0; end
          end else begin
            if (o - st >= 0) m_out[c] = o - st;
            else if (wrap_en[c]) begin m_out[c] = lv; m_tc[c] = 1; end
            else begin m_out[c] = 0; m_tc[c] = (o != 0) ? 1 : 0; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      check("model.out", c, dut_out(c), m_out[c]);
      check("model.tc", c, int'(tc[c]), m_tc[c]);
    end
  end

  task automatic cfg(input int ch, input bit en, input bit ld, input int xm,
                     input bit d, input bit wr, input int lv, input int lim);
    cnt_enb[ch]       = en;
    load[ch]          = ld;
    Xmode[2*ch +: 2]  = 2'(xm);
    dir[ch]           = d;
    wrap_en[ch]       = wr;
    LoadVal[W*ch +: W] = W'(lv);
    limit[W*ch +: W]   = W'(lim);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cnt_enb = '0; load = '0; dir = '0; wrap_en = '0;
    Xmode = '0; LoadVal = '0; limit = '0;
    #12;
    for (int c = 0; c < NC; c++) expect_ch("reset", c, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Step modes 1,2,4,8 after load of 50.
    cfg(0, 0, 1, 0, 1, 1, 50, 4095); step(); expect_ch("mode_load", 0, 50, 0);
    cfg(0, 1, 0, 0, 1, 1, 50, 4095); step(); expect_ch("mode_x1", 0, 51, 0);
    cfg(0, 1, 0, 1, 1, 1, 50, 4095); step(); expect_ch("mode_x2", 0, 53, 0);
    cfg(0, 1, 0, 2, 1, 1, 50, 4095); step(); expect_ch("mode_x4", 0, 57, 0);
    cfg(0, 1, 0, 3, 1, 1, 50, 4095); step(); expect_ch("mode_x8", 0, 65, 0);

    // Up wrap at top of range.
    cfg(0, 0, 1, 3, 1, 1, 4000, 4095); step(); expect_ch("wrap_load", 0, 4000, 0);
    cfg(0, 1, 0, 3, 1, 1, 4000, 4095);
    repeat (10) step();
    expect_ch("wrap_4080", 0, 4080, 0);
    step(); expect_ch("wrap_hit", 0, 4088, 0);
    step(); expect_ch("wrap_tc", 0, 4000, 1);
    step(); expect_ch("wrap_after", 0, 4008, 0);

    // Up saturate.
    cfg(0, 0, 1, 2, 1, 0, 98, 100); step(); expect_ch("sat_load", 0, 98, 0);
    cfg(0, 1, 0, 2, 1, 0, 98, 100); step(); expect_ch("sat_tc", 0, 100, 1);
    step(); expect_ch("sat_hold", 0, 100, 0);

    // Down wrap then down saturate.
    cfg(0, 0, 1, 2, 0, 1, 3, 4095); step(); expect_ch("dn_load", 0, 3, 0);
    cfg(0, 1, 0, 2, 0, 1, 50, 4095); step(); expect_ch("dn_wrap", 0, 50, 1);
    cfg(0, 0, 1, 2, 0, 0, 3, 4095); step(); expect_ch("dn_load2", 0, 3, 0);
    cfg(0, 1, 0, 2, 0, 0, 3, 4095); step(); expect_ch("dn_sat", 0, 0, 1);
    step(); expect_ch("dn_hold", 0, 0, 0);

    // Exact hit going down is not terminal; next step is.
    cfg(0, 0, 1, 2, 0, 1, 4, 4095); step();
    cfg(0, 1, 0, 2, 0, 1, 9, 4095); step(); expect_ch("dn_exact", 0, 0, 0);
    step(); expect_ch("dn_exact_tc", 0, 9, 1);

    // Back-to-back terminal events when LoadVal+step > limit.
    cfg(0, 0, 1, 3, 1, 1, 4090, 4095); step();
    cfg(0, 1, 0, 3, 1, 1, 4090, 4095); step(); expect_ch("b2b_0", 0, 4090, 1);
    step(); expect_ch("b2b_1", 0, 4090, 1);

    // Priority and independence: ch1 loads 10, ch2 loads 200 above its limit.
    cfg(0, 0, 0, 0, 1, 1, 0, 4095);
    cfg(1, 0, 1, 1, 1, 1, 10, 4095);
    cfg(2, 0, 1, 0, 1, 0, 200, 100);
    step(); expect_ch("mc_ld1", 1, 10, 0); expect_ch("mc_ld2", 2, 200, 0);
    cfg(0, 1, 1, 0, 1, 1, 7, 4095);
    cfg(1, 1, 0, 1, 1, 1, 10, 4095);
    cfg(2, 1, 0, 0, 1, 0, 200, 100);
    step();
    expect_ch("mc_prio", 0, 7, 0);
    expect_ch("mc_ch1", 1, 12, 0);
    expect_ch("mc_over", 2, 100, 1);
    cfg(0, 0, 0, 0, 1, 1, 7, 4095);
    cfg(1, 0, 0, 1, 1, 1, 10, 4095);
    cfg(2, 0, 0, 0, 1, 0, 200, 100);

    // Reset mid-count on ch3 at 37.
    cfg(3, 0, 1, 0, 1, 0, 30, 4095); step();
    cfg(3, 1, 0, 0, 1, 0, 30, 4095);
    repeat (7) step();
    expect_ch("pre_rst", 3, 37, 0);
    #2 rst_n = 1'b0;
    #1 expect_ch("async_rst", 3, 0, 0);
    expect_ch("async_rst0", 0, 0, 0);
    step(); expect_ch("rst_hold", 3, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    step(); expect_ch("rel_1", 3, 1, 0);
    step(); expect_ch("rel_2", 3, 2, 0);
    step(); expect_ch("rel_3", 3, 3, 0);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_counter_bank
